mux4_scan_sequencer: RTL
========================

// Module: mux4_scan_sequencer
// PURPOSE
//  Sequences the select lines of the 4:1 transmission-gate mux through all four
//  inputs, waits a settle time per select, samples the mux output and packs the
//  four samples into one word. Sits directly around the mux: drives S1/S0
//  upstream of it and consumes out1 downstream of it. Results are offered on a
//  valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks per select value; sample on the last one (legal range 1..255)
//  CNT_W          8  width of settle down-counter; must hold SETTLE_CYCLES-1
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  start    in   1  request one scan; sampled only in IDLE
//  abort    in   1  synchronous cancel of a scan in progress
//  mux_in   in   1  mux out1
//  S1       out  1  mux select MSB (registered)
//  S0       out  1  mux select LSB (registered)
//  busy     out  1  high in SETTLE
//  valid    out  1  data_o holds a complete scan
//  ready    in   1  consumer accepts data_o when valid & ready
//  data_o   out  4  {D,C,B,A} = samples at sel 3,2,1,0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, S1=S0=0, busy=0, valid=0, data_o=0, cnt=0.
//  - Select map (fixed by mux): {S1,S0}=00->A, 01->B, 10->C, 11->D.
//  - IDLE: S1S0=00. start=1 at edge E0 -> SETTLE, sel=0, cnt=SETTLE_CYCLES-1.
//  - SETTLE: each edge cnt--. Edge with cnt==0: data_o[sel]<=mux_in;
//    if sel<3: sel++, cnt reload; if sel==3: -> VALID, valid<=1 at that edge.
//  - Latency: bit n captured at edge E0+(n+1)*SETTLE_CYCLES; valid rises at
//    E0+4*SETTLE_CYCLES. No sample before the settle count expires.
//  - data_o bits not yet captured in a scan hold prior values; data_o only
//    guaranteed while valid=1.
//  - VALID: data_o, S1S0=11 held stable until valid&ready. Handshake edge ->
//    IDLE, valid<=0, S1S0<=00. valid never drops without ready (except reset).
//  - start ignored outside IDLE (no queueing); start in VALID is lost.
//  - abort in SETTLE -> IDLE next edge, S1S0<=00, valid stays 0, partial data
//    discarded. abort in IDLE/VALID ignored. abort and start together in IDLE:
//    abort wins, stay IDLE.
//  - Reset asserted mid-scan or in VALID: immediate return to reset values.
//  - sel is 2 bits and never wraps past 3; S1=sel[1], S0=sel[0] registered.
//  - SETTLE_CYCLES=1: one clock per select, 4 clocks start-to-valid.
// STRUCTURE
//  - Shared package: state enum {IDLE, SETTLE, VALID}, SEL_A..SEL_D constants
//    (2'b00..2'b11), default SETTLE_CYCLES.
//  - One sub-module natural: settle_counter (loadable down-counter, zero flag).
//  - Rest is one FSM + 4-bit capture register in this file.
// TESTING (bench instantiates the 4:1 mux netlist on S1/S0/mux_in)
//  1. SETTLE_CYCLES=4, A=1,B=0,C=1,D=1, start pulse at E0 -> busy E1..E16,
//     valid at E16, data_o=4'b1101, S1S0 sequence 00,01,10,11 each 4 clocks.
//  2. Valid held, ready=0 for 10 clocks -> data_o=1101 and S1S0=11 stable;
//     ready=1 -> next edge valid=0, S1S0=00, IDLE.
//  3. start pulsed at E5 during scan -> ignored; single valid at E16 only.
//  4. abort at E9 (sel=2) -> IDLE at E10, valid never rises; new start
//     with A..D=0,1,0,0 -> data_o=4'b0010.
//  5. rst_n low at E7 asynchronously -> S1=S0=busy=valid=0 same instant,
//     data_o=0; release then start -> normal scan.
//  6. SETTLE_CYCLES=1, inputs 1,1,1,0 (A..D) -> valid 4 clocks after start,
//     data_o=4'b0111; back-to-back start on handshake-next cycle accepted.

Source files
------------

// File: rtl/mux4_scan_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Select codes follow the mux wiring: 00->A, 01->B, 10->C, 11->D.
package mux4_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    VALID
  } state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam int DEFAULT_SETTLE_CYCLES = 4;

endpackage

// File: rtl/mux4_scan_sequencer_settle_counter.sv
// Loadable down-counter that parks at zero and flags it.
// A load always takes priority over counting.
module settle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Steps the mux selects through A..D, samples out1 on the last settle clock
// of each select and presents the packed {D,C,B,A} word on valid/ready.
module mux4_scan_sequencer
  import mux4_scan_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_in,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] data_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] sel;
  logic       cnt_load;
  logic       cnt_enable;
  logic       cnt_zero;

  // Reload on scan start and on every select step except the final one.
  always_comb begin
    cnt_load = 1'b0;
    case (state)
      IDLE:    cnt_load = start && !abort;
      SETTLE:  cnt_load = !abort && cnt_zero && (sel != SEL_D);
      default: cnt_load = 1'b0;
    endcase
  end

  assign cnt_enable = (state == SETTLE);

  settle_counter #(
    .CNT_W(CNT_W)
  ) u_settle_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .enable    (cnt_enable),
    .load_value(RELOAD),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= SEL_A;
      busy   <= 1'b0;
      valid  <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= SETTLE;
            sel   <= SEL_A;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            sel   <= SEL_A;
            busy  <= 1'b0;
          end else if (cnt_zero) begin
            data_o[sel] <= mux_in;
            if (sel == SEL_D) begin
              state <= VALID;
              busy  <= 1'b0;
              valid <= 1'b1;
            end else begin
              sel <= sel + 2'd1;
            end
          end
        end
        VALID: begin
          // Selects stay parked on D until the word is taken.
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
            sel   <= SEL_A;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= SEL_A;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign S1 = sel[1];
  assign S0 = sel[0];

endmodule
